// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: opcode constants (also used by the control decoder), fetch FSM encoding, widths.
package instr_fetch_pkg;

  localparam int INST_W = 32;
  localparam int OP_W   = 6;

  localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
  localparam logic [OP_W-1:0] OP_AND  = 6'd2;
  localparam logic [OP_W-1:0] OP_OR   = 6'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd4;
  localparam logic [OP_W-1:0] OP_SLT  = 6'd5;
  localparam logic [OP_W-1:0] OP_LW   = 6'd10;
  localparam logic [OP_W-1:0] OP_SW   = 6'd11;
  localparam logic [OP_W-1:0] OP_ADDI = 6'd12;
  localparam logic [OP_W-1:0] OP_LUI  = 6'd13;
  localparam logic [OP_W-1:0] OP_ORI  = 6'd14;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'd20;
  localparam logic [OP_W-1:0] OP_BNE  = 6'd21;
  localparam logic [OP_W-1:0] OP_JMP  = 6'd30;
  localparam logic [OP_W-1:0] OP_IRET = 6'd31;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_VALID = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } if_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: instruction-memory port, decode handshake, redirect input and bus error.
interface instr_fetch_if;

  logic                               imem_req;
  logic [instr_fetch_pkg::INST_W-1:0] imem_addr;
  logic                               imem_ack;
  logic [instr_fetch_pkg::INST_W-1:0] imem_rdata;
  logic                               inst_valid;
  logic                               inst_ready;
  logic [instr_fetch_pkg::INST_W-1:0] inst;
  logic [instr_fetch_pkg::OP_W-1:0]   op;
  logic [instr_fetch_pkg::INST_W-1:0] inst_pc;
  logic                               illegal;
  logic                               redirect;
  logic [instr_fetch_pkg::INST_W-1:0] redirect_pc;
  logic                               bus_err;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, op, inst_pc, illegal, bus_err,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, op, inst_pc, illegal, bus_err,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_opcode_check.sv
// Combinational opcode legality check; shared with the control decoder.
module opcode_check
  import instr_fetch_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output logic            legal_o
);

  always_comb begin
    legal_o = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
      OP_LW, OP_SW, OP_ADDI, OP_LUI, OP_ORI,
      OP_BEQ, OP_BNE, OP_JMP, OP_IRET: legal_o = 1'b1;
      default:                         legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, req/ack fetch, valid/ready hand-off to decode, redirect and timeout.
// Build option IFETCH_ILLEGAL_TRAP_EN: illegal opcodes are not presented; fetch jumps to TRAP_PC.
//   state | meaning
//   FETCH | request pending at pc
//   VALID | instruction held for decode
//   DRAIN | redirected while a request was open; wait out the stale ack
//   ERR   | fetch timed out; idle until redirect
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [INST_W-1:0] TRAP_PC     = 32'h0000_0080,
  parameter int unsigned       TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

`ifdef IFETCH_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] WAIT_TC = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  if_state_e         state_q, state_d;
  logic [INST_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] drain_addr_q, drain_addr_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [INST_W-1:0] inst_pc_q, inst_pc_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              run_q;

  logic req, ack, timeout, legal, bus_err;

  opcode_check u_opcode_check (
    .op_i    (bus.imem_rdata[INST_W-1 -: OP_W]),
    .legal_o (legal)
  );

  // run_q keeps imem_req low until the first clock after reset release
  assign req     = run_q && (state_q == ST_FETCH || state_q == ST_DRAIN);
  assign ack     = req && bus.imem_ack;
  assign timeout = (TIMEOUT_CYC != 0) && req && !bus.imem_ack && (wait_q == WAIT_TC);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    illegal_d    = TRAP_EN ? 1'b0 : illegal_q;
    wait_d       = '0;
    bus_err      = 1'b0;

    if ((TIMEOUT_CYC != 0) && req && !bus.imem_ack && !bus.redirect && !timeout)
      wait_d = wait_q + 1'b1;

    if (bus.redirect) begin
      pc_d = bus.redirect_pc & ~32'h3;
      case (state_q)
        ST_FETCH: begin
          if (req && !bus.imem_ack) begin
            state_d      = ST_DRAIN;
            drain_addr_d = pc_q;
          end
        end
        ST_DRAIN: if (ack) state_d = ST_FETCH;
        default:  state_d = ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (ack) begin
            if (TRAP_EN && !legal) begin
              pc_d      = TRAP_PC;
              illegal_d = 1'b1;
            end else begin
              inst_d    = bus.imem_rdata;
              inst_pc_d = pc_q;
              illegal_d = !legal;
              pc_d      = pc_q + 32'd4;
              state_d   = ST_VALID;
            end
          end else if (timeout) begin
            bus_err = 1'b1;
            state_d = ST_ERR;
          end
        end
        ST_DRAIN: begin
          if (ack) begin
            state_d = ST_FETCH;
          end else if (timeout) begin
            bus_err = 1'b1;
            state_d = ST_ERR;
          end
        end
        ST_VALID: if (bus.inst_ready) state_d = ST_FETCH;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      illegal_q    <= 1'b0;
      wait_q       <= '0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      illegal_q    <= illegal_d;
      wait_q       <= wait_d;
      run_q        <= 1'b1;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign bus.inst_valid = (state_q == ST_VALID);
  assign bus.inst       = inst_q;
  assign bus.op         = inst_q[INST_W-1 -: OP_W];
  assign bus.inst_pc    = inst_pc_q;
  assign bus.illegal    = illegal_q;
  assign bus.bus_err    = bus_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch against a behavioural fetch/decode model.
module tb_instr_fetch;

  localparam logic [63:0] LEGAL_MASK = 64'h0000_0000_C030_7C3F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch #(
    .RESET_PC    (32'h0000_0000),
    .TRAP_PC     (32'h0000_0080),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_pc;

  function automatic logic ref_illegal(input logic [5:0] o);
    return !LEGAL_MASK[o];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One full fetch from exp_pc: optional ack wait, then optional decode backpressure.
  task automatic fetch_one(input int ack_dly, input int rdy_dly, input logic [5:0] opv);
    logic [31:0] rnd, word;
    rnd  = $urandom();
    word = {opv, rnd[25:0]};
    chk("req", bus.imem_req, 1);
    chk("addr", bus.imem_addr, exp_pc);
    for (int i = 0; i < ack_dly; i++) begin
      step();
      chk("req_wait", bus.imem_req, 1);
      chk("addr_wait", bus.imem_addr, exp_pc);
      chk("valid_wait", bus.inst_valid, 0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom();
    chk("valid", bus.inst_valid, 1);
    chk("inst", bus.inst, word);
    chk("op", bus.op, opv);
    chk("inst_pc", bus.inst_pc, exp_pc);
    chk("illegal", bus.illegal, ref_illegal(opv));
    chk("req_in_valid", bus.imem_req, 0);
    for (int i = 0; i < rdy_dly; i++) begin
      step();
      chk("inst_held", bus.inst, word);
      chk("op_held", bus.op, opv);
      chk("valid_held", bus.inst_valid, 1);
      chk("no_req_bp", bus.imem_req, 0);
    end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    exp_pc = exp_pc + 32'd4;
    chk("valid_drop", bus.inst_valid, 0);
  endtask

  initial begin
    logic [31:0] rnd, word, old_pc;
    logic [5:0]  opv;

    rst             = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    #3;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", bus.inst_valid, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_op", bus.op, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_bus_err", bus.bus_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    exp_pc = 32'h0;

    // sequential zero-wait fetches: 0, 4, 8
    fetch_one(0, 0, 6'd0);
    fetch_one(0, 0, 6'd12);
    fetch_one(0, 0, 6'd31);

    // decode backpressure
    fetch_one(0, 5, 6'd20);

    // randomized legal traffic
    for (int n = 0; n < 20; n++) begin
      opv = 6'(($urandom_range(0, 63)));
      for (int k = 0; k < 64 && ref_illegal(opv); k++) opv = 6'(opv + 6'd1);
      fetch_one(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), opv);
    end

    // redirect while a request waits: drain the stale ack, then fetch at 0x100
    old_pc = exp_pc;
    chk("pre_redir_req", bus.imem_req, 1);
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h103;
    step();
    bus.redirect    = 1'b0;
    chk("drain_req", bus.imem_req, 1);
    chk("drain_addr", bus.imem_addr, old_pc);
    chk("drain_valid", bus.inst_valid, 0);
    step();
    chk("drain_addr2", bus.imem_addr, old_pc);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ack   = 1'b0;
    chk("post_drain_valid", bus.inst_valid, 0);
    chk("post_drain_req", bus.imem_req, 1);
    chk("post_drain_addr", bus.imem_addr, 32'h100);
    exp_pc = 32'h100;
    fetch_one(0, 0, 6'd3);

    // redirect together with inst_ready: redirect wins
    rnd = $urandom();
    word = {6'd5, rnd[25:0]};
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_ack = 1'b0;
    chk("rv_valid", bus.inst_valid, 1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    bus.inst_ready  = 1'b1;
    step();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b0;
    chk("rv_dropped", bus.inst_valid, 0);
    chk("rv_req", bus.imem_req, 1);
    chk("rv_addr", bus.imem_addr, 32'h200);

    // timeout with TIMEOUT_CYC=4: bus_err on the 4th waiting cycle
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("to_bus_err_c%0d", c), bus.bus_err, (c == 4) ? 1 : 0);
      chk($sformatf("to_req_c%0d", c), bus.imem_req, 1);
      step();
    end
    chk("err_req", bus.imem_req, 0);
    chk("err_bus_err", bus.bus_err, 0);
    chk("err_valid", bus.inst_valid, 0);
    step();
    chk("err_req_hold", bus.imem_req, 0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h303;
    step();
    bus.redirect = 1'b0;
    chk("resume_req", bus.imem_req, 1);
    chk("resume_addr", bus.imem_addr, 32'h300);
    exp_pc = 32'h300;
    fetch_one(1, 0, 6'd11);

    // illegal opcode 6
`ifdef IFETCH_ILLEGAL_TRAP_EN
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = {6'd6, 26'h12_3456};
    step();
    bus.imem_ack = 1'b0;
    chk("trap_valid", bus.inst_valid, 0);
    chk("trap_illegal", bus.illegal, 1);
    chk("trap_addr", bus.imem_addr, 32'h80);
    chk("trap_req", bus.imem_req, 1);
    step();
    chk("trap_illegal_pulse", bus.illegal, 0);
    chk("trap_valid2", bus.inst_valid, 0);
    exp_pc = 32'h80;
    fetch_one(0, 0, 6'd1);
`else
    fetch_one(0, 1, 6'd6);
`endif

    // async reset in the middle of VALID
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = {6'd13, 26'h3FF_FFFF};
    step();
    bus.imem_ack = 1'b0;
    chk("ar_valid_before", bus.inst_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", bus.inst_valid, 0);
    chk("ar_req", bus.imem_req, 0);
    chk("ar_addr", bus.imem_addr, 32'h0);
    chk("ar_inst", bus.inst, 0);
    chk("ar_op", bus.op, 0);
    chk("ar_inst_pc", bus.inst_pc, 0);
    chk("ar_illegal", bus.illegal, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    exp_pc = 32'h0;
    fetch_one(0, 0, 6'd21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
